// File: rtl/onehot_encoder.sv
// 4:2 priority encoder with non-one-hot error flag, valid/ready handshake,
// 2-entry output FIFO and saturating error counter.
module onehot_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  input  logic             d3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a,
  output logic             b,
  output logic             out_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t     state, state_nxt;
  logic [2:0] head, tail, beat;
  logic [1:0] code;
  logic       enc_err, is_onehot;
  logic       push, pop;
  logic       head_ld_new, head_ld_tail, tail_ld;

  always_comb begin
    code = '0;
    if (d3)      code = 2'b11;
    else if (d2) code = 2'b10;
    else if (d1) code = 2'b01;
  end

  // Exactly one bit set: odd parity and no pair set together.
  assign is_onehot = (d0 ^ d1 ^ d2 ^ d3) &&
                     !((d0 & d1) | (d0 & d2) | (d0 & d3) |
                       (d1 & d2) | (d1 & d3) | (d2 & d3));
  assign enc_err   = !is_onehot;
  assign beat      = {code, enc_err};

  assign in_ready  = !rst && (state != TWO);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // In ONE a simultaneous push+pop replaces the head directly; tail is only
  // used while two beats are held.
  always_comb begin
    state_nxt    = state;
    head_ld_new  = 1'b0;
    head_ld_tail = 1'b0;
    tail_ld      = 1'b0;
    case (state)
      EMPTY: if (push) begin
        state_nxt   = ONE;
        head_ld_new = 1'b1;
      end
      ONE: begin
        if (push && pop) begin
          head_ld_new = 1'b1;
        end else if (push) begin
          state_nxt = TWO;
          tail_ld   = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (pop) begin
        state_nxt    = ONE;
        head_ld_tail = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (head_ld_new)       head <= beat;
      else if (head_ld_tail) head <= tail;
      if (tail_ld)           tail <= beat;
    end
  end

  assign {a, b, out_err} = head;

  always_ff @(posedge clk) begin
    if (rst || err_clr)
      err_count <= '0;
    else if (push && enc_err && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

endmodule

// File: tb/tb_onehot_encoder.sv
// Self-checking bench for onehot_encoder: two instances (CNT_W=8 and CNT_W=2)
// share stimulus and are compared against a queue-based reference model.
module tb_onehot_encoder;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, err_clr;
  logic       d0, d1, d2, d3;
  logic       rdy8, vld8, a8, b8, e8;
  logic       rdy2, vld2, a2, b2, e2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [2:0]  q[$];
  int unsigned m8 = 0;
  int unsigned m2 = 0;

  always #5 clk = ~clk;

  onehot_encoder #(.CNT_W(8)) u_big (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_valid(vld8), .out_ready(out_ready), .a(a8), .b(b8), .out_err(e8),
    .err_clr(err_clr), .err_count(cnt8)
  );

  onehot_encoder #(.CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .out_valid(vld2), .out_ready(out_ready), .a(a2), .b(b2), .out_err(e2),
    .err_clr(err_clr), .err_count(cnt2)
  );

  function automatic logic [1:0] enc(input logic [3:0] dv);
    for (int i = 3; i >= 0; i--)
      if (dv[i]) return 2'(i);
    return 2'b00;
  endfunction

  function automatic logic [19:0] exp_vec();
    logic [2:0] h;
    logic v, r;
    v = (q.size() != 0);
    r = !rst && (q.size() < 2);
    h = v ? q[0] : 3'b000;
    return {v, r, h, 8'(m8), v, r, h, 2'(m2)};
  endfunction

  function automatic logic [19:0] obs_vec();
    logic [2:0] h8, h2;
    h8 = vld8 ? {a8, b8, e8} : 3'b000;
    h2 = vld2 ? {a2, b2, e2} : 3'b000;
    return {vld8, rdy8, h8, cnt8, vld2, rdy2, h2, cnt2};
  endfunction

  task automatic drive(input logic v, input logic [3:0] dv, input logic ordy);
    in_valid  = v;
    {d3, d2, d1, d0} = dv;
    out_ready = ordy;
  endtask

  // Advance one clock and step the reference model with the driven inputs.
  task automatic tick();
    logic [3:0] dv;
    logic [2:0] bt;
    bit push, pop;
    dv   = {d3, d2, d1, d0};
    push = in_valid && !rst && (q.size() < 2);
    pop  = (q.size() != 0) && out_ready;
    bt   = {enc(dv), ($countones(dv) != 1)};
    @(posedge clk);
    if (rst) begin
      q.delete();
      m8 = 0;
      m2 = 0;
    end else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(bt);
      if (err_clr) begin
        m8 = 0;
        m2 = 0;
      end else if (push && bt[0]) begin
        if (m8 < 255) m8++;
        if (m2 < 3)   m2++;
      end
    end
    #1;
  endtask

  function automatic logic [3:0] rand_err_word();
    logic [3:0] dv;
    do dv = 4'($urandom_range(0, 15)); while ($countones(dv) == 1);
    return dv;
  endfunction

  task automatic test_reset();
    logic [19:0] o, e;
    rst = 1'b1; err_clr = 1'b0;
    drive(1'b0, 4'b0000, 1'b0);
    tick(); tick();
    tests++;
    if ({rdy8, vld8, a8, b8, e8, cnt8, rdy2, vld2, a2, b2, e2, cnt2} !== '0) begin
      fails++;
      $display("FAIL reset_values: got rdy=%b vld=%b ab=%b%b err=%b cnt=%0d want all zero",
               rdy8, vld8, a8, b8, e8, cnt8);
    end
    rst = 1'b0; #1;
    o = obs_vec(); e = exp_vec(); tests++;
    if (o !== e) begin fails++; $display("FAIL reset_release: got %h want %h", o, e); end
  endtask

  task automatic test_onehot();
    logic [19:0] o, e;
    logic [3:0] dv;
    for (int i = 0; i < 4; i++) begin
      dv = 4'b0001 << i;
      drive(1'b1, dv, 1'b1); tick();
      drive(1'b0, 4'b0000, 1'b1);
      o = obs_vec(); e = exp_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL onehot_%b: got %h want %h", dv, o, e); end
      tick();
      o = obs_vec(); e = exp_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL onehot_drain_%0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_errors();
    logic [19:0] o, e;
    logic [3:0] words [2];
    words[0] = 4'b0000;
    words[1] = 4'b1010;
    foreach (words[i]) begin
      drive(1'b1, words[i], 1'b1); tick();
      drive(1'b0, 4'b0000, 1'b1);
      o = obs_vec(); e = exp_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL error_word_%b: got %h want %h", words[i], o, e); end
      tick();
    end
    tests++;
    if (cnt8 !== 8'd2) begin fails++; $display("FAIL error_count_two: got %0d want 2", cnt8); end
  endtask

  task automatic test_backpressure();
    logic [19:0] o, e;
    logic [3:0] words [3];
    words[0] = 4'b0010; words[1] = 4'b0100; words[2] = 4'b1000;
    foreach (words[i]) begin
      drive(1'b1, words[i], 1'b0); tick();
      o = obs_vec(); e = exp_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL hold_push_%0d: got %h want %h", i, o, e); end
    end
    tests++;
    if (rdy8 !== 1'b0 || {a8, b8} !== 2'b01) begin
      fails++;
      $display("FAIL hold_stable: got rdy=%b ab=%b%b want rdy=0 ab=01", rdy8, a8, b8);
    end
    out_ready = 1'b1; tick();
    for (int c = 0; c < 5; c++) begin
      o = obs_vec(); e = exp_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL release_%0d: got %h want %h", c, o, e); end
      if (c == 0) in_valid = 1'b1;
      if (c == 1) in_valid = 1'b0;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] o, e;
    drive(1'b1, 4'b0001 << $urandom_range(0, 3), 1'b0); tick();
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 4'b0001 << $urandom_range(0, 3), 1'b1); tick();
      o = obs_vec(); e = exp_vec(); tests++;
      if (o !== e || vld8 !== 1'b1 || rdy8 !== 1'b1) begin
        fails++; $display("FAIL back_to_back_%0d: got %h want %h", c, o, e);
      end
    end
    drive(1'b0, 4'b0000, 1'b1); tick(); tick();
  endtask

  task automatic test_saturation();
    logic [19:0] o, e;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, rand_err_word(), 1'b1); tick();
      o = obs_vec(); e = exp_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL sat_push_%0d: got %h want %h", c, o, e); end
    end
    tests++;
    if (cnt2 !== 2'd3) begin fails++; $display("FAIL sat_value: got %0d want 3", cnt2); end
    err_clr = 1'b1;
    drive(1'b1, rand_err_word(), 1'b1); tick();
    err_clr = 1'b0; drive(1'b0, 4'b0000, 1'b1);
    tests++;
    if (cnt2 !== 2'd0 || cnt8 !== 8'd0) begin
      fails++; $display("FAIL clr_wins: got cnt2=%0d cnt8=%0d want 0 0", cnt2, cnt8);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [19:0] o, e;
    drive(1'b1, 4'b1010, 1'b0); tick();
    drive(1'b1, 4'b0100, 1'b0); tick();
    rst = 1'b1; drive(1'b0, 4'b0000, 1'b0); #1;
    tests++;
    if (rdy8 !== 1'b0) begin fails++; $display("FAIL rst_ready_low: got %b want 0", rdy8); end
    tick();
    tests++;
    if ({vld8, a8, b8, e8, cnt8} !== '0) begin
      fails++; $display("FAIL rst_mid_values: got vld=%b ab=%b%b err=%b cnt=%0d want zeros",
                        vld8, a8, b8, e8, cnt8);
    end
    rst = 1'b0; out_ready = 1'b1; #1;
    for (int c = 0; c < 3; c++) begin
      o = obs_vec(); e = exp_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL rst_no_stale_%0d: got %h want %h", c, o, e); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [19:0] o, e;
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 49) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? 4'b0001 << $urandom_range(0, 3)
                                       : 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) != 0);
      tick();
      o = obs_vec(); e = exp_vec(); tests++;
      if (o !== e) begin fails++; $display("FAIL random_%0d: got %h want %h", c, o, e); end
    end
    rst = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
